// File: rtl/pot_axis_emulator.sv
// pot_axis_emulator: Atari 5200 POKEY pot-scan emulation from analog/digital controller axes.
module pot_axis_emulator #(
  parameter int POT_CENTER = 114,
  parameter int POT_MAX    = 228
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        LINE_TICK,
  input  logic        FAST_TICK,
  input  logic        FAST_SCAN,
  input  logic        POTGO,
  input  logic [63:0] AXES,
  input  logic [3:0]  ANALOG_EN,
  input  logic [15:0] JOY_DIR,
  output logic [7:0]  POT_DONE,
  output logic [7:0]  ALLPOT,
  output logic [63:0] POT_VALUES,
  output logic [7:0]  SCAN_COUNT
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t     r_state;
  logic [7:0] r_count;
  logic [7:0] r_done;
  logic [7:0] r_val [8];
  logic [7:0] r_tgt [8];
  logic [7:0] w_tgt [8];
  logic       w_lo  [8];
  logic       w_hi  [8];
  logic       w_tick;
  logic [7:0] w_next;
  assign w_tick = FAST_SCAN ? FAST_TICK : LINE_TICK;
  assign w_next = r_count + 8'd1;
  // Mapped targets stay within 2..226, so wrap-around 8-bit arithmetic is exact.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_lo[i]  = JOY_DIR[4*(i/2) + 1 + 2*(i%2)];
      w_hi[i]  = JOY_DIR[4*(i/2) + 2*(i%2)];
      w_tgt[i] = ANALOG_EN[i/2]
        ? 8'(POT_CENTER) + AXES[8*i +: 8] - {{3{AXES[8*i+7]}}, AXES[8*i+3 +: 5]}
        : (w_lo[i] && !w_hi[i]) ? 8'd2
        : (w_hi[i] && !w_lo[i]) ? 8'(POT_MAX - 2)
        : 8'(POT_CENTER);
    end
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_count <= 8'(POT_MAX);
      r_done  <= '1;
      for (int i = 0; i < 8; i++) begin
        r_val[i] <= 8'(POT_MAX);
        r_tgt[i] <= 8'(POT_CENTER);
      end
    end else if (POTGO) begin
      r_state <= SCAN;
      r_count <= '0;
      r_done  <= '0;
      for (int i = 0; i < 8; i++) r_tgt[i] <= w_tgt[i];
    end else if (r_state == SCAN && w_tick) begin
      r_count <= w_next;
      for (int i = 0; i < 8; i++)
        if (!r_done[i] && (w_next == r_tgt[i] || w_next == 8'(POT_MAX))) begin
          r_done[i] <= 1'b1;
          r_val[i]  <= w_next;
        end
      if (w_next == 8'(POT_MAX)) r_state <= IDLE;
    end
  end
  // Unfinished pots read the live counter, as real POKEY does.
  for (genvar g = 0; g < 8; g++) begin : g_pot
    assign POT_VALUES[8*g +: 8] = r_done[g] ? r_val[g] : r_count;
  end
  assign POT_DONE   = r_done;
  assign ALLPOT     = ~r_done;
  assign SCAN_COUNT = r_count;
endmodule
